// File: rtl/triangle_wave_seq_if.sv
// Configuration and sample-stream handshake bundle for triangle_wave_seq.
// master = system/testbench side, slave = sequencer side.
interface triangle_wave_seq_if #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 24
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ACC_W-1:0]  cfg_fcw;
  logic [3:0]        cfg_sel;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output cfg_valid, cfg_fcw, cfg_sel, sample_ready,
    input  cfg_ready, sample, sample_valid
  );

  modport slave (
    input  cfg_valid, cfg_fcw, cfg_sel, sample_ready,
    output cfg_ready, sample, sample_valid
  );
endinterface

// File: rtl/triangle_wave_seq.sv
// Phase-accumulator sequencer for a combinational triangle lookup: drives address/duty,
// applies new config only at period wrap, and streams registered samples downstream.
module triangle_wave_seq #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 24,
  parameter int SEL_MAX = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_tick,
  triangle_wave_seq_if.slave  bus,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [3:0]          o_sel,
  input  logic [DATA_W-1:0]   i_wave_data,
  output logic                o_period_start,
  output logic                o_overrun
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_fcw_act;
  logic [ACC_W-1:0]  r_fcw_sh;
  logic [3:0]        r_sel_act;
  logic [3:0]        r_sel_sh;
  logic              r_sh_full;
  logic              r_cap;
  logic              r_valid;
  logic              r_ps;
  logic              r_ovr;
  logic [DATA_W-1:0] r_sample;
  logic [ACC_W:0]    w_sum;
  logic              w_tick_run;
  logic              w_wrap;
  logic              w_cfg_acc;
  logic              w_load;

  function automatic logic [3:0] clamp_sel(input logic [3:0] sel);
    if (sel > 4'(SEL_MAX)) begin
      clamp_sel = 4'(SEL_MAX);
    end else begin
      clamp_sel = sel;
    end
  endfunction

  // Next state plus the per-cycle tick, wrap, config-accept and capture decisions
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_en) w_state_nxt = ST_RUN;
        else      w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (i_en) w_state_nxt = ST_RUN;
        else      w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_tick_run = (r_state == ST_RUN) && i_en && i_tick;
    w_sum      = {1'b0, r_acc} + {1'b0, r_fcw_act};
    w_wrap     = w_tick_run && w_sum[ACC_W];
    w_cfg_acc  = bus.cfg_valid && !r_sh_full;
    // A pending capture loads unless the held sample is still waiting to be taken
    w_load     = r_cap && (!r_valid || bus.sample_ready);
  end

  // State, phase and config registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_fcw_act <= '0;
      r_sel_act <= 4'd0;
      r_fcw_sh  <= '0;
      r_sel_sh  <= 4'd0;
      r_sh_full <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN && !i_en) begin
        r_acc <= '0;
      end else if (w_tick_run) begin
        r_acc <= w_sum[ACC_W-1:0];
      end
      // Idle has no period to tear, so config (or a leftover shadow) lands directly
      if (r_state == ST_IDLE) begin
        if (r_sh_full) begin
          r_fcw_act <= r_fcw_sh;
          r_sel_act <= r_sel_sh;
          r_sh_full <= 1'b0;
        end else if (w_cfg_acc) begin
          r_fcw_act <= bus.cfg_fcw;
          r_sel_act <= clamp_sel(bus.cfg_sel);
        end
      end else begin
        if (w_wrap && r_sh_full) begin
          r_fcw_act <= r_fcw_sh;
          r_sel_act <= r_sel_sh;
          r_sh_full <= 1'b0;
        end else if (w_cfg_acc) begin
          r_fcw_sh  <= bus.cfg_fcw;
          r_sel_sh  <= clamp_sel(bus.cfg_sel);
          r_sh_full <= 1'b1;
        end
      end
    end
  end

  // Capture pipeline, output sample register and status pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap    <= 1'b0;
      r_valid  <= 1'b0;
      r_sample <= '0;
      r_ps     <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_cap <= w_tick_run;
      r_ps  <= w_wrap;
      r_ovr <= r_cap && !w_load;
      if (w_load) begin
        r_sample <= i_wave_data;
        r_valid  <= 1'b1;
      end else if (r_valid && bus.sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_addr           = r_acc[ACC_W-1 -: ADDR_W];
  assign o_sel            = r_sel_act;
  assign o_period_start   = r_ps;
  assign o_overrun        = r_ovr;
  assign bus.cfg_ready    = !r_sh_full;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_valid;

endmodule

// File: tb/tb_triangle_wave_seq.sv
// Self-checking bench for triangle_wave_seq: scenario tasks compared cycle by cycle
// against a phase/config/handshake reference model built from the behavioural rules.
module tb_triangle_wave_seq;
  localparam int ACC_W   = 32;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 24;
  localparam int SEL_MAX = 10;
  localparam logic [41:0] RST_OUTS = {10'd0, 4'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic              clk = 1'b0;
  logic              rst, en, tick;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [DATA_W-1:0] wave;
  logic              ps, ovr;
  logic [41:0]       dut_outs;

  triangle_wave_seq_if #(.ACC_W(ACC_W), .DATA_W(DATA_W)) bus ();

  triangle_wave_seq #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_MAX(SEL_MAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_tick(tick), .bus(bus),
    .o_addr(addr), .o_sel(sel), .i_wave_data(wave),
    .o_period_start(ps), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // Triangle lookup: rises over sel*1024/10 addresses, falls over the rest
  function automatic logic [23:0] lut(input logic [9:0] a, input logic [3:0] s);
    longint unsigned ai, rise;
    ai   = 64'(a);
    rise = (64'd1024 * 64'(s)) / 64'd10;
    if (ai < rise) return 24'((ai * 64'hFFFFFF) / rise);
    else           return 24'(((64'd1024 - ai) * 64'hFFFFFF) / (64'd1024 - rise));
  endfunction

  assign wave     = lut(addr, sel);
  assign dut_outs = {addr, sel, bus.sample, bus.sample_valid, ps, ovr, bus.cfg_ready};

  // Reference model state
  logic [31:0] m_ph = 32'd0, m_fcw = 32'd0, m_sh_fcw = 32'd0;
  logic [3:0]  m_sel = 4'd0, m_sh_sel = 4'd0;
  logic [23:0] m_sample = 24'd0;
  bit m_sh_full = 1'b0, m_run = 1'b0, m_cap = 1'b0, m_valid = 1'b0, m_ps = 1'b0, m_ovr = 1'b0;

  function automatic logic [41:0] model_outs();
    return {m_ph[31:22], m_sel, m_sample, m_valid, m_ps, m_ovr, ~m_sh_full};
  endfunction

  function automatic void model_edge();
    logic [32:0] sum;
    logic [3:0]  csel;
    bit          rdy_now;
    if (rst) begin
      m_ph = 32'd0; m_fcw = 32'd0; m_sel = 4'd0; m_sh_full = 1'b0; m_run = 1'b0;
      m_cap = 1'b0; m_valid = 1'b0; m_sample = 24'd0; m_ps = 1'b0; m_ovr = 1'b0;
      return;
    end
    rdy_now = !m_sh_full;
    m_ovr = 1'b0;
    if (m_cap) begin
      if (!m_valid || bus.sample_ready) begin
        m_valid = 1'b1;
        m_sample = lut(m_ph[31:22], m_sel);
      end else m_ovr = 1'b1;
    end else if (m_valid && bus.sample_ready) m_valid = 1'b0;
    m_cap = 1'b0;
    m_ps  = 1'b0;
    if (m_run && en && tick) begin
      sum   = {1'b0, m_ph} + {1'b0, m_fcw};
      m_ph  = sum[31:0];
      m_cap = 1'b1;
      m_ps  = sum[32];
      if (sum[32] && m_sh_full) begin
        m_fcw = m_sh_fcw; m_sel = m_sh_sel; m_sh_full = 1'b0;
      end
    end
    if (bus.cfg_valid && rdy_now) begin
      csel = (bus.cfg_sel > 4'd10) ? 4'd10 : bus.cfg_sel;
      if (m_run) begin
        m_sh_fcw = bus.cfg_fcw; m_sh_sel = csel; m_sh_full = 1'b1;
      end else begin
        m_fcw = bus.cfg_fcw; m_sel = csel;
      end
    end
    if (m_run && !en) m_ph = 32'd0;
    if (!m_run && m_sh_full) begin
      m_fcw = m_sh_fcw; m_sel = m_sh_sel; m_sh_full = 1'b0;
    end
    m_run = en;
  endfunction

  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tick = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_fcw = 32'd0; bus.cfg_sel = 4'd0; bus.sample_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clk_step();
      n_checks++;
      if (dut_outs !== RST_OUTS) $display("FAIL reset cyc=%0d got=%h exp=%h", i, dut_outs, RST_OUTS);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    int n_ticks = 0;
    bus.cfg_valid = 1'b1; bus.cfg_fcw = 32'h0040_0000; bus.cfg_sel = 4'd5;
    clk_step();
    bus.cfg_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 4 == 1);
      if (tick) n_ticks++;
      clk_step();
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL ramp cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
    tick = 1'b0;
    n_checks++;
    if (addr !== 10'(n_ticks)) $display("FAIL ramp_addr got=%0d exp=%0d", addr, n_ticks);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int n_ps = 0;
    en = 1'b0;
    clk_step();
    bus.cfg_valid = 1'b1; bus.cfg_fcw = 32'h4000_0000; bus.cfg_sel = 4'd10;
    clk_step();
    bus.cfg_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 4 == 1);
      clk_step();
      if (ps) n_ps++;
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL wrap cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
    tick = 1'b0;
    n_checks++;
    if (n_ps != 1) $display("FAIL wrap_pulses got=%0d exp=1", n_ps);
    else n_pass++;
  endtask

  task automatic test_shadow();
    bit accepted = 1'b0;
    int n_sel2 = 0;
    bus.cfg_valid = 1'b1; bus.cfg_fcw = 32'h4000_0000; bus.cfg_sel = 4'd2;
    clk_step();
    n_checks++;
    if (dut_outs !== model_outs()) $display("FAIL shadow_first got=%h exp=%h", dut_outs, model_outs());
    else n_pass++;
    bus.cfg_fcw = 32'h2000_0000; bus.cfg_sel = 4'd3;
    for (int i = 0; i < 60 && !accepted; i++) begin
      tick = (i % 4 == 1);
      accepted = bus.cfg_valid && bus.cfg_ready;
      clk_step();
      if (sel == 4'd2) n_sel2++;
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL shadow cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
    bus.cfg_valid = 1'b0;
    n_checks++;
    if (!accepted || n_sel2 == 0) $display("FAIL shadow_stall accepted=%0d sel2_cycles=%0d exp accepted=1 sel2>0", accepted, n_sel2);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 4 == 1);
      clk_step();
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL shadow_commit cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
    tick = 1'b0;
  endtask

  task automatic test_backpressure();
    int n_ovr = 0;
    int n_dlv = 0;
    for (int i = 0; i < 3; i++) clk_step();
    bus.sample_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick = (i % 4 == 1) && (i < 12);
      clk_step();
      if (ovr) n_ovr++;
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
    tick = 1'b0;
    bus.sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.sample_valid) n_dlv++;
      clk_step();
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL bp_release cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
    n_checks++;
    if (n_ovr != 2 || n_dlv != 1) $display("FAIL bp_counts overruns=%0d delivered=%0d exp 2 and 1", n_ovr, n_dlv);
    else n_pass++;
  endtask

  task automatic test_clamp_stop();
    int n_dlv = 0;
    en = 1'b0;
    clk_step();
    bus.cfg_valid = 1'b1; bus.cfg_fcw = 32'h0100_0000; bus.cfg_sel = 4'd15;
    clk_step();
    bus.cfg_valid = 1'b0;
    n_checks++;
    if (sel !== 4'd10) $display("FAIL clamp got=%0d exp=10", sel);
    else n_pass++;
    bus.sample_ready = 1'b0;
    en = 1'b1;
    clk_step();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick = (i % 3 == 1);
      clk_step();
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL stop cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
    tick = 1'b0;
    n_checks++;
    if (addr !== 10'd0 || bus.sample_valid !== 1'b1) $display("FAIL stop_state addr=%0d valid=%0d exp 0 and 1", addr, bus.sample_valid);
    else n_pass++;
    bus.sample_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.sample_valid) n_dlv++;
      clk_step();
    end
    n_checks++;
    if (n_dlv != 1) $display("FAIL stop_deliver got=%0d exp=1", n_dlv);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en               = ($urandom_range(0, 19) != 0);
      tick             = ($urandom_range(0, 1) == 1);
      bus.sample_ready = ($urandom_range(0, 3) != 0);
      bus.cfg_valid    = ($urandom_range(0, 7) == 0);
      bus.cfg_fcw      = $urandom() >> $urandom_range(0, 8);
      bus.cfg_sel      = 4'($urandom_range(0, 15));
      clk_step();
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
    tick = 1'b0; bus.cfg_valid = 1'b0; bus.sample_ready = 1'b1;
  endtask

  task automatic test_reset_midrun();
    en = 1'b1;
    bus.cfg_valid = 1'b1; bus.cfg_fcw = 32'h0000_0001; bus.cfg_sel = 4'd7;
    for (int i = 0; i < 4; i++) begin
      tick = (i % 2 == 1);
      clk_step();
    end
    bus.cfg_valid = 1'b0; tick = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clk_step();
      n_checks++;
      if (dut_outs !== RST_OUTS) $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, dut_outs, RST_OUTS);
      else n_pass++;
    end
    rst = 1'b0; tick = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clk_step();
      n_checks++;
      if (dut_outs !== model_outs()) $display("FAIL reset_after cyc=%0d got=%h exp=%h", i, dut_outs, model_outs());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_wrap();
    test_shadow();
    test_backpressure();
    test_clamp_stop();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
